// File: rtl/dat_sched_pkg.sv
// Shared state encoding, channel indices and default widths for the DAT transfer scheduler.
package dat_sched_pkg;

   localparam int unsigned BLK_W_DEFAULT = 4;
   localparam int unsigned TO_W_DEFAULT  = 16;

   localparam int unsigned CH_CPU = 0;
   localparam int unsigned CH_DMA = 1;

   typedef enum logic [3:0] {
      IDLE,
      ARB,
      WAIT_READY,
      STROBE,
      WAIT_COMPLETE,
      ACK,
      WAIT_ACK_LOW,
      STOP,
      ERROR,
      DONE
   } state_t;

endpackage

// File: rtl/dat_xfer_scheduler_rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to the channel not granted last.
module rr_arbiter2
   import dat_sched_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       valid,
   output logic       pick
);

   always_comb begin
      valid = |req;
      pick  = 1'(CH_CPU);
      if (req == 2'b11)
         pick = ~last_grant;
      else if (req[CH_DMA])
         pick = 1'(CH_DMA);
   end

endmodule

// File: rtl/dat_xfer_scheduler.sv
// Shares the DAT phys between CPU (ch0) and DMA (ch1) with round-robin arbitration and a completion timeout.
// Build option DAT_SCHED_STOP_CMD_EN adds a STOP/CMD12 request phase after multi-block transfers.
module dat_xfer_scheduler
   import dat_sched_pkg::*;
#(
   parameter int unsigned BLK_W = BLK_W_DEFAULT,
   parameter int unsigned TO_W  = TO_W_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0,
   input  logic             wr0,
   input  logic [BLK_W-1:0] blocks0,
   input  logic             req1,
   input  logic             wr1,
   input  logic [BLK_W-1:0] blocks1,
   input  logic [TO_W-1:0]  timeout_limit,
   input  logic             fifo_okay,
   input  logic             serial_ready,
   input  logic             complete,
   input  logic             ack_in,
   output logic             strobe_out,
   output logic             ack_out,
   output logic [BLK_W-1:0] blocks,
   output logic             multiple,
   output logic             writereadphys,
   output logic [1:0]       grant,
   output logic [1:0]       done,
   output logic             error,
`ifdef DAT_SCHED_STOP_CMD_EN
   output logic             stop_req,
   input  logic             stop_ack,
`endif
   output logic             busy
);

   state_t           state, state_next;
   logic             arb_valid, arb_pick, last_grant;
   logic [BLK_W-1:0] sel_blocks;
   logic             sel_wr;
   logic [TO_W-1:0]  to_cnt, to_cnt_inc;
   logic             timeout_hit;

   rr_arbiter2 u_arb (
      .req        ({req1, req0}),
      .last_grant (last_grant),
      .valid      (arb_valid),
      .pick       (arb_pick)
   );

   assign sel_blocks = arb_pick ? blocks1 : blocks0;
   assign sel_wr     = arb_pick ? wr1 : wr0;

   // Timeout fires on the WAIT_COMPLETE clock whose count reaches the limit.
   assign to_cnt_inc  = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;
   assign timeout_hit = (timeout_limit != '0) && (to_cnt_inc == timeout_limit);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:          if (req0 || req1) state_next = ARB;
         ARB: begin
            if (!arb_valid)
               state_next = IDLE;
            else if (sel_blocks == '0)
               state_next = DONE;
            else
               state_next = WAIT_READY;
         end
         WAIT_READY:    if (serial_ready && fifo_okay) state_next = STROBE;
         STROBE:        state_next = WAIT_COMPLETE;
         WAIT_COMPLETE: begin
            if (complete)
               state_next = ACK;
            else if (timeout_hit)
               state_next = ERROR;
         end
         ACK:           if (ack_in) state_next = WAIT_ACK_LOW;
         WAIT_ACK_LOW: begin
            if (!ack_in) begin
`ifdef DAT_SCHED_STOP_CMD_EN
               state_next = multiple ? STOP : DONE;
`else
               state_next = DONE;
`endif
            end
         end
`ifdef DAT_SCHED_STOP_CMD_EN
         STOP:          if (stop_ack) state_next = DONE;
`endif
         ERROR:         if (!ack_in && !complete) state_next = DONE;
         DONE:          state_next = IDLE;
         default:       state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         to_cnt <= '0;
      else if (state == STROBE)
         to_cnt <= '0;
      else if (state == WAIT_COMPLETE)
         to_cnt <= to_cnt_inc;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         grant         <= '0;
         last_grant    <= 1'(CH_DMA);
         blocks        <= '0;
         writereadphys <= 1'b0;
         multiple      <= 1'b0;
         error         <= 1'b0;
      end else if (state == ARB && arb_valid) begin
         grant         <= arb_pick ? 2'b10 : 2'b01;
         last_grant    <= arb_pick;
         blocks        <= sel_blocks;
         writereadphys <= sel_wr;
         multiple      <= (sel_blocks > BLK_W'(1));
         error         <= (sel_blocks == '0);
      end else if (state == WAIT_COMPLETE && !complete && timeout_hit) begin
         error <= 1'b1;
      end else if (state == DONE) begin
         grant         <= '0;
         blocks        <= '0;
         writereadphys <= 1'b0;
         multiple      <= 1'b0;
      end
   end

   assign strobe_out = (state == STROBE) || (state == WAIT_COMPLETE) || (state == ACK);
   assign ack_out    = (state == ACK);
   assign done       = (state == DONE) ? grant : 2'b00;
   assign busy       = (state != IDLE);
`ifdef DAT_SCHED_STOP_CMD_EN
   assign stop_req   = (state == STOP);
`endif

endmodule

// File: tb/tb_dat_xfer_scheduler.sv
// Directed bench for dat_xfer_scheduler: bench-side phys responder, per-cycle transaction model, literal timing checks.
module tb_dat_xfer_scheduler;

   localparam int BLK_W = 4;
   localparam int TO_W  = 16;

   localparam int W_STB_HI = 0;
   localparam int W_DONE   = 2;
   localparam int W_ACK    = 3;
   localparam int W_GRANT  = 4;

   logic             clock;
   logic             reset;
   logic             req0, wr0, req1, wr1;
   logic [BLK_W-1:0] blocks0, blocks1;
   logic [TO_W-1:0]  timeout_limit;
   logic             fifo_okay, serial_ready, complete, ack_in;
   logic             strobe_out, ack_out, multiple, writereadphys, error, busy;
   logic [BLK_W-1:0] blocks;
   logic [1:0]       grant, done;
`ifdef DAT_SCHED_STOP_CMD_EN
   logic             stop_req, stop_ack;
`endif

   int checks = 0;
   int errors = 0;

   int phys_en    = 1;
   int phys_delay = 40;

   dat_xfer_scheduler #(.BLK_W(BLK_W), .TO_W(TO_W)) dut (
      .clock         (clock),
      .reset         (reset),
      .req0          (req0),
      .wr0           (wr0),
      .blocks0       (blocks0),
      .req1          (req1),
      .wr1           (wr1),
      .blocks1       (blocks1),
      .timeout_limit (timeout_limit),
      .fifo_okay     (fifo_okay),
      .serial_ready  (serial_ready),
      .complete      (complete),
      .ack_in        (ack_in),
      .strobe_out    (strobe_out),
      .ack_out       (ack_out),
      .blocks        (blocks),
      .multiple      (multiple),
      .writereadphys (writereadphys),
      .grant         (grant),
      .done          (done),
      .error         (error),
`ifdef DAT_SCHED_STOP_CMD_EN
      .stop_req      (stop_req),
      .stop_ack      (stop_ack),
`endif
      .busy          (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   function automatic int all_outs();
      int v;
      v = int'({strobe_out, ack_out, blocks, multiple, writereadphys, grant, done, error, busy});
`ifdef DAT_SCHED_STOP_CMD_EN
      v = v | (int'(stop_req) << 16);
`endif
      return v;
   endfunction

   function automatic logic cond(input int sel);
      case (sel)
         W_STB_HI: return strobe_out;
         W_DONE:   return done != 2'b00;
         W_ACK:    return ack_out;
         W_GRANT:  return grant != 2'b00;
         default:  return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int budget, output int n);
      n = 0;
      while (!cond(sel) && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (!cond(sel)) chk($sformatf("wait_sel%0d_expired", sel), 0, 1);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(1);
   endtask

   // Phys responder: complete after phys_delay strobe clocks, ack_in follows ack_out,
   // everything drops once the scheduler releases strobe and ack.
   int pcnt = 0;
   initial begin
      complete = 1'b0;
      ack_in   = 1'b0;
`ifdef DAT_SCHED_STOP_CMD_EN
      stop_ack = 1'b0;
`endif
      forever begin
         @(posedge clock);
         #1;
         if (reset) begin
            complete = 1'b0;
            ack_in   = 1'b0;
            pcnt     = 0;
         end else if (!strobe_out && !ack_out) begin
            complete = 1'b0;
            ack_in   = 1'b0;
            pcnt     = 0;
         end else begin
            if (phys_en != 0 && !complete) begin
               pcnt++;
               if (pcnt >= phys_delay) complete = 1'b1;
            end
            if (ack_out) ack_in = 1'b1;
         end
      end
   end

`ifdef DAT_SCHED_STOP_CMD_EN
   int scnt = 0;
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (stop_req) begin
            scnt++;
            if (scnt >= 3) stop_ack = 1'b1;
         end else begin
            scnt     = 0;
            stop_ack = 1'b0;
         end
      end
   end
`endif

   // Transaction model: who must win each grant, what must stay latched while owned.
   initial begin
      logic [1:0]       prev_grant, prev_done;
      int               m_owner;
      int               exp_ch;
      logic             m_last;
      logic [BLK_W-1:0] m_blocks;
      logic             m_wr;
      prev_grant = 2'b00;
      prev_done  = 2'b00;
      m_owner    = -1;
      m_last     = 1'b1;
      m_blocks   = '0;
      m_wr       = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_grant = 2'b00;
            prev_done  = 2'b00;
            m_owner    = -1;
            m_last     = 1'b1;
         end else begin
            chk("grant_onehot", int'($onehot0(grant)), 1);
            if (prev_grant == 2'b00 && grant != 2'b00) begin
               if (req0 && req1) exp_ch = m_last ? 0 : 1;
               else              exp_ch = req1 ? 1 : 0;
               chk("grant_owner", int'(grant), (exp_ch == 1) ? 2 : 1);
               m_owner  = exp_ch;
               m_last   = (exp_ch == 1);
               m_blocks = (exp_ch == 1) ? blocks1 : blocks0;
               m_wr     = (exp_ch == 1) ? wr1 : wr0;
            end
            if (grant != 2'b00) begin
               chk("latched_blocks", int'(blocks), int'(m_blocks));
               chk("latched_dir", int'(writereadphys), int'(m_wr));
               chk("latched_multiple", int'(multiple), (m_blocks > 1) ? 1 : 0);
               chk("busy_while_owned", int'(busy), 1);
            end
            if (done != 2'b00) begin
               chk("done_owner", int'(done), (m_owner == 1) ? 2 : (m_owner == 0) ? 1 : 0);
               chk("done_one_clock", int'(prev_done), 0);
            end
            if (prev_done != 2'b00) chk("grant_release", int'(grant), 0);
            if (strobe_out) chk("strobe_owned", int'(grant != 2'b00), 1);
            if (ack_out)    chk("ack_with_strobe", int'(strobe_out), 1);
            prev_grant = grant;
            prev_done  = done;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1);
   end

   initial begin
      int n, k, t_hi, t_ack, t_done, bad, stop_hi, stop_ack_overlap;
      int dly[2];
      int exp_hi[2];
      int exp_err[2];
      reset         = 1'b1;
      req0          = 1'b0;
      wr0           = 1'b0;
      blocks0       = '0;
      req1          = 1'b0;
      wr1           = 1'b0;
      blocks1       = '0;
      timeout_limit = '0;
      fifo_okay     = 1'b1;
      serial_ready  = 1'b1;
      cyc(3);
      chk("reset_outputs", all_outs(), 0);
      reset = 1'b0;
      cyc(2);

      // Single 2-block read, complete after 40 clocks.
      wr0 = 1'b0; blocks0 = 4'd2; req0 = 1'b1;
      wait_for(W_STB_HI, 20, n);
      chk("t1_multiple", int'(multiple), 1);
      chk("t1_blocks", int'(blocks), 2);
      chk("t1_dir", int'(writereadphys), 0);
      blocks0 = 4'd7; wr0 = 1'b1;
      t_hi = 0; t_ack = 0; t_done = 0;
      while (done == 2'b00 && t_done < 200) begin
         if (strobe_out) t_hi++;
         if (ack_out) t_ack++;
         @(negedge clock);
         t_done++;
      end
      chk("t1_strobe_cycles", t_hi, 41);
      chk("t1_ack_cycles", t_ack, 1);
      chk("t1_done_latency", t_done, 42);
      chk("t1_done", int'(done), 1);
      chk("t1_error", int'(error), 0);
      req0 = 1'b0; blocks0 = 4'd2; wr0 = 1'b0;
      cyc(3);

      // Tie from reset: ch0, ch1, ch0.
      do_reset();
      phys_delay = 5;
      wr0 = 1'b1; blocks0 = 4'd1; wr1 = 1'b0; blocks1 = 4'd3;
      req0 = 1'b1; req1 = 1'b1;
      wait_for(W_DONE, 300, n);
      chk("t2_first_done", int'(done), 1);
      k = 0;
      @(negedge clock);
      while (grant == 2'b00 && k < 10) begin
         k++;
         @(negedge clock);
      end
      chk("t2_grant_gap", k, 2);
      chk("t2_second_grant", int'(grant), 2);
      wait_for(W_DONE, 300, n);
      chk("t2_second_done", int'(done), 2);
      cyc(1);
      wait_for(W_DONE, 300, n);
      chk("t2_third_done", int'(done), 1);
      req0 = 1'b0; req1 = 1'b0;
      cyc(3);

      // Timeout with limit 100: strobe clock plus 100 waiting clocks.
      timeout_limit = 16'd100; phys_en = 0;
      wr1 = 1'b1; blocks1 = 4'd1; req1 = 1'b1;
      wait_for(W_STB_HI, 20, n);
      t_hi = 0;
      while (strobe_out && t_hi < 300) begin
         t_hi++;
         @(negedge clock);
      end
      chk("t3_strobe_cycles", t_hi, 101);
      chk("t3_error_on_timeout", int'(error), 1);
      chk("t3_no_ack", int'(ack_out), 0);
      cyc(1);
      chk("t3_done", int'(done), 2);
      req1 = 1'b0;
      cyc(1);
      chk("t3_error_sticky", int'(error), 1);
      cyc(2);

      // Backpressure, and error clears on the next grant.
      timeout_limit = '0; phys_en = 1; phys_delay = 10;
      fifo_okay = 1'b0; wr0 = 1'b1; blocks0 = 4'd5; req0 = 1'b1;
      wait_for(W_GRANT, 10, n);
      chk("t5_error_cleared", int'(error), 0);
      bad = 0;
      repeat (50) begin
         @(negedge clock);
         if (strobe_out) bad++;
      end
      serial_ready = 1'b0; fifo_okay = 1'b1;
      repeat (5) begin
         @(negedge clock);
         if (strobe_out) bad++;
      end
      chk("t5_strobe_held_low", bad, 0);
      serial_ready = 1'b1;
      @(negedge clock);
      chk("t5_strobe_latency", int'(strobe_out), 1);
      wait_for(W_DONE, 300, n);
      chk("t5_done", int'(done), 1);
      req0 = 1'b0;
      cyc(3);

      // Zero blocks: no strobe, error, done two clocks after request.
      wr1 = 1'b0; blocks1 = 4'd0; req1 = 1'b1;
      t_done = 0; bad = 0;
      while (done == 2'b00 && t_done < 10) begin
         @(negedge clock);
         t_done++;
         if (strobe_out) bad++;
      end
      chk("t4_done_latency", t_done, 2);
      chk("t4_done", int'(done), 2);
      chk("t4_error", int'(error), 1);
      chk("t4_no_strobe", bad, 0);
      req1 = 1'b0;
      cyc(3);

      // Complete on the limit clock wins; one clock later the timeout wins.
      dly[0] = 21; exp_hi[0] = 22; exp_err[0] = 0;
      dly[1] = 22; exp_hi[1] = 21; exp_err[1] = 1;
      timeout_limit = 16'd20;
      for (int i = 0; i < 2; i++) begin
         phys_delay = dly[i];
         wr0 = 1'b0; blocks0 = 4'd1; req0 = 1'b1;
         wait_for(W_STB_HI, 20, n);
         t_hi = 0;
         while (strobe_out && t_hi < 100) begin
            t_hi++;
            @(negedge clock);
         end
         chk($sformatf("t7_strobe_cycles_%0d", i), t_hi, exp_hi[i]);
         wait_for(W_DONE, 20, n);
         chk($sformatf("t7_done_%0d", i), int'(done), 1);
         chk($sformatf("t7_error_%0d", i), int'(error), exp_err[i]);
         req0 = 1'b0;
         cyc(3);
      end

      // Reset during WAIT_COMPLETE, then a tie must go to ch0.
      timeout_limit = '0; phys_en = 0;
      wr0 = 1'b0; blocks0 = 4'd3; req0 = 1'b1;
      wait_for(W_STB_HI, 20, n);
      cyc(5);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_async_clear", all_outs(), 0);
      req0 = 1'b0;
      cyc(2);
      reset = 1'b0;
      bad = 0;
      repeat (3) begin
         @(negedge clock);
         if (done != 2'b00 || busy) bad++;
      end
      chk("t6_quiet_after_reset", bad, 0);
      phys_en = 1; phys_delay = 5;
      blocks0 = 4'd3; wr0 = 1'b1; blocks1 = 4'd2; wr1 = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      wait_for(W_ACK, 100, n);
      chk("t6_tie_to_ch0", int'(grant), 1);
      t_done = 0; stop_hi = 0; stop_ack_overlap = 0;
      while (done == 2'b00 && t_done < 50) begin
         @(negedge clock);
         t_done++;
`ifdef DAT_SCHED_STOP_CMD_EN
         if (stop_req) stop_hi++;
         if (stop_req && ack_in) stop_ack_overlap++;
`endif
      end
`ifdef DAT_SCHED_STOP_CMD_EN
      chk("t6_ack_to_done", t_done, 5);
      chk("t6_stop_cycles", stop_hi, 3);
      chk("t6_stop_after_ack_low", stop_ack_overlap, 0);
      chk("t6_stop_dropped_at_done", int'(stop_req), 0);
`else
      chk("t6_ack_to_done", t_done, 2);
`endif
      chk("t6_done_ch0", int'(done), 1);
      cyc(1);
      wait_for(W_DONE, 300, n);
      chk("t6_done_ch1", int'(done), 2);
      req0 = 1'b0; req1 = 1'b0;
      cyc(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dat_xfer_scheduler.md
Name: dat_xfer_scheduler

Overview:
Sequences and shares the single DAT physical layer (dat_phys) between two host-side requesters: ch0 = CPU/PIO and ch1 = DMA. It arbitrates round-robin and drives the phys strobe/ack four-phase handshake with block count, multiple and direction. It guards each transfer with a completion timeout and reports per-channel done plus a shared error flag. It sits in the host clock domain, in the place dat_controller occupies today, and presents the same phys-facing signals.

Parameters:
BLK_W, 4, width of block-count fields.
TO_W, 16, width of timeout counter and timeout_limit.

Ports:
clock  in  1  host clock
reset  in  1  asynchronous, active-high reset
req0  in  1  ch0 request, level, held until done[0]
wr0  in  1  ch0 direction, 1 = write, 0 = read
blocks0  in  BLK_W  ch0 block count
req1  in  1  ch1 request
wr1  in  1  ch1 direction
blocks1  in  BLK_W  ch1 block count
timeout_limit  in  TO_W  clocks allowed in WAIT_COMPLETE; 0 disables timeout
fifo_okay  in  1  FIFO ready for the transfer
serial_ready  in  1  phys idle and able to accept strobe
complete  in  1  phys finished all blocks
ack_in  in  1  phys acknowledge of ack_out
strobe_out  out  1  start transfer to phys
ack_out  out  1  acknowledge of complete to phys
blocks  out  BLK_W  block count to phys
multiple  out  1  1 when blocks > 1
writereadphys  out  1  direction to phys
grant  out  2  one-hot owner of the phys
done  out  2  one-cycle per-channel completion pulse
error  out  1  sticky; cleared on next grant
busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, last_grant = 1 (ch0 wins first tie), timeout counter 0. Reset mid-transfer abandons the transfer with no done pulse.
- IDLE: any req → ARB next cycle.
- ARB (1 cycle): single request is granted. Two requests: grant the channel != last_grant. Then:
  - Latch wr/blocks into blocks/writereadphys/multiple. These stay stable until IDLE.
  - Set grant one-hot. Update last_grant. Clear error.
  - If the latched blocks == 0: set error, go to DONE. No strobe is issued.
- WAIT_READY: wait for serial_ready & fifo_okay. Both are checked in the same cycle.
- STROBE: strobe_out = 1, held through WAIT_COMPLETE. Go to WAIT_COMPLETE the same cycle.
- WAIT_COMPLETE: the timeout counter increments every clock.
  - complete = 1 → ACK.
  - Counter == timeout_limit (limit != 0) and complete = 0 → ERROR.
  - complete and the limit reached in the same cycle: complete wins.
- ACK: ack_out = 1, strobe_out held. ack_in = 1 → WAIT_ACK_LOW.
- WAIT_ACK_LOW: strobe_out = 0, ack_out = 0. When ack_in = 0: go to STOP (if enabled and multiple) else DONE.
- ERROR: strobe_out = 0, ack_out = 0, error = 1. Wait for ack_in = 0 and complete = 0, then go to DONE.
- DONE: done[granted] = 1 for exactly one clock, grant → 0. Next state IDLE.
  - A request still high returns to arbitration after IDLE. Minimum gap between grants is 2 clocks.
- Request lines are sampled only in IDLE/ARB. Dropping req mid-transfer is ignored.
- Timeout counter: saturating TO_W-bit, cleared on entry to WAIT_COMPLETE.
- multiple = (blocks > 1). blocks is unsigned BLK_W; no wrap.

Optional Feature:
Macro DAT_SCHED_STOP_CMD_EN.
- When defined:
  - Adds output stop_req and input stop_ack.
  - After a multi-block transfer (multiple = 1), state STOP asserts stop_req until stop_ack = 1, then drops it and goes to DONE. This requests CMD12 from the CMD controller.
  - stop_ack is ignored outside STOP.
  - Single-block and error paths skip STOP.
- When undefined: no ports, no STOP state; WAIT_ACK_LOW goes to DONE directly.

Decomposition:
- Package dat_sched_pkg holds:
  - state encoding: IDLE, ARB, WAIT_READY, STROBE, WAIT_COMPLETE, ACK, WAIT_ACK_LOW, STOP, ERROR, DONE
  - channel index constants CH_CPU = 0, CH_DMA = 1
  - default BLK_W and TO_W
- One sub-module, rr_arbiter2: combinational two-way round-robin pick from req[1:0] and last_grant.
- The FSM, counter and output registers stay in the top level.

Test Plan:
1. Single read: req0 = 1, wr0 = 0, blocks0 = 2; serial_ready = fifo_okay = 1; phys raises complete after 40 clocks. Required: multiple = 1, blocks = 2, writereadphys = 0, strobe_out high until ack_in, ack_out high, done = 2'b01 for 1 clock, error = 0.
2. Simultaneous requests: req0 = req1 = 1 from reset. Required: ch0 granted first, ch1 granted second, done pulses in order 01 then 10. Third tie after that goes to ch0.
3. Timeout: timeout_limit = 100, complete never asserted. Required: ERROR entered exactly 100 clocks after strobe, strobe_out drops, error = 1, done pulse for the owner; error clears on the next grant.
4. Zero blocks: req1 = 1, blocks1 = 0. Required: no strobe_out, error = 1, done = 2'b10 within 3 clocks of req.
5. Backpressure: fifo_okay = 0 for 50 clocks after grant. Required: strobe_out stays 0 until fifo_okay = 1 and serial_ready = 1 together.
6. Reset mid-transfer: assert reset during WAIT_COMPLETE. Required: all outputs 0 immediately (asynchronous), no done pulse, next tie grants ch0. With DAT_SCHED_STOP_CMD_EN and blocks = 3: stop_req rises after ack_in falls and holds until stop_ack, then done.
